// File: rtl/ysyx_24080014_regfile_csr.sv
// GPR file (RV32E/RV32I) plus machine-mode CSR bank with a load-wait commit handshake.
// Optional same-cycle read bypass of the committing write: define YSYX_24080014_REGFILE_BYPASS_EN.
module ysyx_24080014_regfile_csr #(
    parameter int              XLEN        = 32,
    parameter int              NR_REGS     = 32,
    parameter int              ECALL_CAUSE = 11,
    parameter logic [XLEN-1:0] MSTATUS_RST = 32'h0000_1800
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      rs1_addr,
    input  logic [4:0]      rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic [11:0]     csr_raddr,
    output logic [XLEN-1:0] csr_rdata,
    input  logic            wb_valid,
    output logic            wb_ready,
    input  logic            wb_is_load,
    input  logic            mem_ready,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [1:0]      csr_op,
    input  logic            csr_we,
    input  logic [11:0]     csr_waddr,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc
);
    localparam int AW = $clog2(NR_REGS);
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam int MIE_BIT  = 3;
    localparam int MPIE_BIT = 7;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_WAIT_MEM = 1'b1} state_e;

    state_e          state_r, state_nxt_s;
    logic            commit_s, gpr_we_s, rs1_byp_s, rs2_byp_s;
    logic [XLEN-1:0] gpr_r [NR_REGS];
    logic [XLEN-1:0] mstatus_r, mtvec_r, mepc_r, mcause_r;
    logic [XLEN-1:0] mstatus_nxt_s, mtvec_nxt_s, mepc_nxt_s, mcause_nxt_s;

    function automatic logic [XLEN-1:0] csr_select(input logic [11:0] addr,
                                                    input logic [XLEN-1:0] ms, tv, ep, mc);
        case (addr)
            CSR_MSTATUS: csr_select = ms;
            CSR_MTVEC:   csr_select = tv;
            CSR_MEPC:    csr_select = ep;
            CSR_MCAUSE:  csr_select = mc;
            default:     csr_select = {XLEN{1'b0}};
        endcase
    endfunction

    // Commit FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= ST_IDLE;
        else        state_r <= state_nxt_s;
    end

    // Commit FSM next-state
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (wb_valid && wb_is_load && !mem_ready) state_nxt_s = ST_WAIT_MEM;
                else                                      state_nxt_s = ST_IDLE;
            end
            ST_WAIT_MEM: begin
                if (wb_valid && mem_ready) state_nxt_s = ST_IDLE;
                else                       state_nxt_s = ST_WAIT_MEM;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Commit FSM outputs
    always_comb begin
        wb_ready = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (wb_valid && wb_is_load && !mem_ready) wb_ready = 1'b0;
                else                                      wb_ready = 1'b1;
            end
            ST_WAIT_MEM: wb_ready = mem_ready;
            default:     wb_ready = 1'b1;
        endcase
    end

    assign commit_s = wb_valid && wb_ready;
    // Indices beyond NR_REGS (RV32E) and x0 are silently not written
    assign gpr_we_s = commit_s && wb_we && (wb_rd != 5'd0) && ({27'd0, wb_rd} < NR_REGS);

    // GPR storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NR_REGS; i++) gpr_r[i] <= {XLEN{1'b0}};
        end else if (gpr_we_s) begin
            gpr_r[wb_rd[AW-1:0]] <= wb_data;
        end else begin
            gpr_r <= gpr_r;
        end
    end

    // CSR update rules; ecall/mret take priority over an explicit CSR write
    always_comb begin
        mstatus_nxt_s = mstatus_r;
        mtvec_nxt_s   = mtvec_r;
        mepc_nxt_s    = mepc_r;
        mcause_nxt_s  = mcause_r;
        if (commit_s) begin
            case (csr_op)
                2'd1: begin
                    mepc_nxt_s              = pc;
                    mcause_nxt_s            = XLEN'(ECALL_CAUSE);
                    mstatus_nxt_s[MPIE_BIT] = mstatus_r[MIE_BIT];
                    mstatus_nxt_s[MIE_BIT]  = 1'b0;
                end
                2'd2: begin
                    mstatus_nxt_s[MIE_BIT]  = mstatus_r[MPIE_BIT];
                    mstatus_nxt_s[MPIE_BIT] = 1'b1;
                end
                default: begin
                    if (csr_we) begin
                        case (csr_waddr)
                            CSR_MSTATUS: mstatus_nxt_s = csr_wdata;
                            CSR_MTVEC:   mtvec_nxt_s   = csr_wdata;
                            CSR_MEPC:    mepc_nxt_s    = csr_wdata;
                            CSR_MCAUSE:  mcause_nxt_s  = csr_wdata;
                            default:     mstatus_nxt_s = mstatus_r;
                        endcase
                    end else begin
                        mstatus_nxt_s = mstatus_r;
                    end
                end
            endcase
        end else begin
            mstatus_nxt_s = mstatus_r;
        end
    end

    // CSR registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstatus_r <= MSTATUS_RST;
            mtvec_r   <= {XLEN{1'b0}};
            mepc_r    <= {XLEN{1'b0}};
            mcause_r  <= {XLEN{1'b0}};
        end else begin
            mstatus_r <= mstatus_nxt_s;
            mtvec_r   <= mtvec_nxt_s;
            mepc_r    <= mepc_nxt_s;
            mcause_r  <= mcause_nxt_s;
        end
    end

`ifdef YSYX_24080014_REGFILE_BYPASS_EN
    assign rs1_byp_s = gpr_we_s && (wb_rd == rs1_addr);
    assign rs2_byp_s = gpr_we_s && (wb_rd == rs2_addr);
    assign csr_rdata = csr_select(csr_raddr, mstatus_nxt_s, mtvec_nxt_s, mepc_nxt_s, mcause_nxt_s);
`else
    assign rs1_byp_s = 1'b0;
    assign rs2_byp_s = 1'b0;
    assign csr_rdata = csr_select(csr_raddr, mstatus_r, mtvec_r, mepc_r, mcause_r);
`endif

    // GPR read ports
    always_comb begin
        rs1_data = {XLEN{1'b0}};
        rs2_data = {XLEN{1'b0}};
        if (rs1_byp_s)                                             rs1_data = wb_data;
        else if ((rs1_addr != 5'd0) && ({27'd0, rs1_addr} < NR_REGS)) rs1_data = gpr_r[rs1_addr[AW-1:0]];
        else                                                       rs1_data = {XLEN{1'b0}};
        if (rs2_byp_s)                                             rs2_data = wb_data;
        else if ((rs2_addr != 5'd0) && ({27'd0, rs2_addr} < NR_REGS)) rs2_data = gpr_r[rs2_addr[AW-1:0]];
        else                                                       rs2_data = {XLEN{1'b0}};
    end

    // Next-PC selection for trap entry / return
    always_comb begin
        next_pc = pc + {{(XLEN-3){1'b0}}, 3'd4};
        case (csr_op)
            2'd1:    next_pc = mtvec_r;
            2'd2:    next_pc = mepc_r;
            default: next_pc = pc + {{(XLEN-3){1'b0}}, 3'd4};
        endcase
    end
endmodule

// File: tb/tb_ysyx_24080014_regfile_csr.sv
// Randomised and directed bench for ysyx_24080014_regfile_csr, run on a 32-entry and a 16-entry instance.
module tb_ysyx_24080014_regfile_csr;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  rs1_addr, rs2_addr, wb_rd;
    logic [11:0] csr_raddr, csr_waddr;
    logic        wb_valid, wb_is_load, mem_ready, wb_we, csr_we;
    logic [1:0]  csr_op;
    logic [31:0] wb_data, csr_wdata, pc;
    logic [31:0] a_rs1, a_rs2, a_csr, a_npc, b_rs1, b_rs2, b_csr, b_npc;
    logic        a_ready, b_ready;

    logic [31:0] m_gpr [32];
    logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ysyx_24080014_regfile_csr #(.NR_REGS(32)) dut (
        .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(a_rs1), .rs2_data(a_rs2), .csr_raddr(csr_raddr), .csr_rdata(a_csr),
        .wb_valid(wb_valid), .wb_ready(a_ready), .wb_is_load(wb_is_load), .mem_ready(mem_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .csr_op(csr_op), .csr_we(csr_we),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .pc(pc), .next_pc(a_npc));

    ysyx_24080014_regfile_csr #(.NR_REGS(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1), .rs2_data(b_rs2), .csr_raddr(csr_raddr), .csr_rdata(b_csr),
        .wb_valid(wb_valid), .wb_ready(b_ready), .wb_is_load(wb_is_load), .mem_ready(mem_ready),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .csr_op(csr_op), .csr_we(csr_we),
        .csr_waddr(csr_waddr), .csr_wdata(csr_wdata), .pc(pc), .next_pc(b_npc));

    function automatic logic m_commit();
        return rst_n && wb_valid && (!wb_is_load || mem_ready);
    endfunction

    // CSR contents after committing the current inputs: {mstatus, mtvec, mepc, mcause}
    function automatic logic [127:0] m_csr_after();
        logic [31:0] ms, tv, ep, mc;
        ms = m_mstatus; tv = m_mtvec; ep = m_mepc; mc = m_mcause;
        if (csr_op == 2'd1) begin
            ep = pc; mc = 32'd11; ms[7] = m_mstatus[3]; ms[3] = 1'b0;
        end else if (csr_op == 2'd2) begin
            ms[3] = m_mstatus[7]; ms[7] = 1'b1;
        end else if (csr_we) begin
            if (csr_waddr == 12'h300)      ms = csr_wdata;
            else if (csr_waddr == 12'h305) tv = csr_wdata;
            else if (csr_waddr == 12'h341) ep = csr_wdata;
            else if (csr_waddr == 12'h342) mc = csr_wdata;
        end
        return {ms, tv, ep, mc};
    endfunction

    function automatic logic [31:0] exp_gpr(input logic [4:0] a, input int lim);
        logic [31:0] v;
        v = (a == 5'd0 || int'(a) >= lim) ? 32'd0 : m_gpr[a];
`ifdef YSYX_24080014_REGFILE_BYPASS_EN
        if (m_commit() && wb_we && wb_rd != 5'd0 && int'(wb_rd) < lim && wb_rd == a) v = wb_data;
`endif
        return v;
    endfunction

    function automatic logic [31:0] exp_csr(input logic [11:0] a);
        logic [127:0] v;
        v = {m_mstatus, m_mtvec, m_mepc, m_mcause};
`ifdef YSYX_24080014_REGFILE_BYPASS_EN
        if (m_commit()) v = m_csr_after();
`endif
        case (a)
            12'h300: return v[127:96];
            12'h305: return v[95:64];
            12'h341: return v[63:32];
            12'h342: return v[31:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] exp_npc();
        if (csr_op == 2'd1) return m_mtvec;
        if (csr_op == 2'd2) return m_mepc;
        return pc + 32'd4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'd0;
        m_mstatus = 32'h0000_1800; m_mtvec = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0;
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_is_load = 1'b0; mem_ready = 1'b0; wb_we = 1'b0; wb_rd = 5'd0;
        wb_data = 32'd0; csr_op = 2'd0; csr_we = 1'b0; csr_waddr = 12'd0; csr_wdata = 32'd0;
        pc = 32'd0;
    endtask

    // Advance one clock edge, updating the model with whatever commits on it
    task automatic tick();
        logic [127:0] c;
        if (m_commit()) begin
            if (wb_we && wb_rd != 5'd0) m_gpr[wb_rd] = wb_data;
            c = m_csr_after();
            {m_mstatus, m_mtvec, m_mepc, m_mcause} = c;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        idle_inputs(); rs1_addr = 5'd0; rs2_addr = 5'd0; csr_raddr = 12'h300;
        rst_n = 1'b0; model_reset();
        @(posedge clk); @(posedge clk); #1;
        for (int i = 0; i < 32; i++) begin
            rs1_addr = 5'(i); rs2_addr = 5'(31 - i); #1;
            n_total++; if (a_rs1 !== 32'd0) $display("FAIL reset_rs1[%0d]: got %h want 0", i, a_rs1); else n_pass++;
            n_total++; if (b_rs2 !== 32'd0) $display("FAIL reset_rs2_16[%0d]: got %h want 0", 31 - i, b_rs2); else n_pass++;
        end
        n_total++; if (a_csr !== 32'h0000_1800) $display("FAIL reset_mstatus: got %h want 00001800", a_csr); else n_pass++;
        n_total++; if (a_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", a_ready); else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        idle_inputs(); wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF; rs1_addr = 5'd5; #2;
        n_total++; if (a_ready !== 1'b1) $display("FAIL wr_ready: got %b want 1", a_ready); else n_pass++;
        n_total++; if (a_rs1 !== exp_gpr(5'd5, 32)) $display("FAIL wr_same_cycle: got %h want %h", a_rs1, exp_gpr(5'd5, 32)); else n_pass++;
        tick(); idle_inputs(); #2;
        n_total++; if (a_rs1 !== 32'hDEAD_BEEF) $display("FAIL wr_read_x5: got %h want deadbeef", a_rs1); else n_pass++;
        n_total++; if (b_rs1 !== 32'hDEAD_BEEF) $display("FAIL wr_read_x5_16: got %h want deadbeef", b_rs1); else n_pass++;
        wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h1234_5678; rs1_addr = 5'd0;
        tick(); idle_inputs(); #2;
        n_total++; if (a_rs1 !== 32'd0) $display("FAIL wr_x0: got %h want 0", a_rs1); else n_pass++;
    endtask

    task automatic test_load_wait();
        idle_inputs(); rs1_addr = 5'd7;
        wb_valid = 1'b1; wb_is_load = 1'b1; wb_we = 1'b1; wb_rd = 5'd7; wb_data = 32'hA5A5_0007;
        for (int c = 0; c < 3; c++) begin
            #2;
            n_total++; if (a_ready !== 1'b0) $display("FAIL load_wait_ready[%0d]: got %b want 0", c, a_ready); else n_pass++;
            n_total++; if (a_rs1 !== 32'd0) $display("FAIL load_wait_noupd[%0d]: got %h want 0", c, a_rs1); else n_pass++;
            tick();
        end
        mem_ready = 1'b1; #2;
        n_total++; if (a_ready !== 1'b1) $display("FAIL load_done_ready: got %b want 1", a_ready); else n_pass++;
        tick(); idle_inputs(); #2;
        n_total++; if (a_rs1 !== 32'hA5A5_0007) $display("FAIL load_data: got %h want a5a50007", a_rs1); else n_pass++;
        // Reset asserted while waiting for memory
        wb_valid = 1'b1; wb_is_load = 1'b1; wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h9999_0009;
        tick(); #2;
        rst_n = 1'b0; model_reset(); wb_valid = 1'b0; #1;
        n_total++; if (a_ready !== 1'b1) $display("FAIL load_rst_idle: got %b want 1", a_ready); else n_pass++;
        n_total++; if (a_rs1 !== 32'd0) $display("FAIL load_rst_clear: got %h want 0", a_rs1); else n_pass++;
        tick(); rst_n = 1'b1; mem_ready = 1'b1; rs1_addr = 5'd9;
        tick(); mem_ready = 1'b0; #2;
        n_total++; if (a_rs1 !== 32'd0) $display("FAIL load_rst_nowrite: got %h want 0", a_rs1); else n_pass++;
    endtask

    task automatic test_ecall_mret();
        idle_inputs(); wb_valid = 1'b1; csr_we = 1'b1; csr_waddr = 12'h305; csr_wdata = 32'h8000_0100; tick();
        csr_waddr = 12'h300; csr_wdata = 32'h0000_1808; tick();
        idle_inputs(); wb_valid = 1'b1; csr_op = 2'd1; pc = 32'h8000_0040;
        csr_we = 1'b1; csr_waddr = 12'h305; csr_wdata = 32'hDEAD_0000;
        wb_we = 1'b1; wb_rd = 5'd10; wb_data = 32'h0BAD_F00D; csr_raddr = 12'h341; #2;
        n_total++; if (a_npc !== 32'h8000_0100) $display("FAIL ecall_npc: got %h want 80000100", a_npc); else n_pass++;
        n_total++; if (a_csr !== exp_csr(12'h341)) $display("FAIL ecall_mepc_same: got %h want %h", a_csr, exp_csr(12'h341)); else n_pass++;
        tick(); idle_inputs(); rs1_addr = 5'd10; #2;
        n_total++; if (a_csr !== 32'h8000_0040) $display("FAIL ecall_mepc: got %h want 80000040", a_csr); else n_pass++;
        csr_raddr = 12'h342; #1;
        n_total++; if (a_csr !== 32'd11) $display("FAIL ecall_mcause: got %h want 0000000b", a_csr); else n_pass++;
        csr_raddr = 12'h300; #1;
        n_total++; if (a_csr !== 32'h0000_1880) $display("FAIL ecall_mstatus: got %h want 00001880", a_csr); else n_pass++;
        csr_raddr = 12'h305; #1;
        n_total++; if (a_csr !== 32'h8000_0100) $display("FAIL ecall_wr_suppressed: got %h want 80000100", a_csr); else n_pass++;
        n_total++; if (a_rs1 !== 32'h0BAD_F00D) $display("FAIL ecall_gpr: got %h want 0badf00d", a_rs1); else n_pass++;
        wb_valid = 1'b1; csr_op = 2'd2; pc = 32'h0000_1234; csr_we = 1'b1; csr_waddr = 12'h341; csr_wdata = 32'd0; #2;
        n_total++; if (a_npc !== 32'h8000_0040) $display("FAIL mret_npc: got %h want 80000040", a_npc); else n_pass++;
        tick(); idle_inputs(); csr_raddr = 12'h300; #2;
        n_total++; if (a_csr !== 32'h0000_1888) $display("FAIL mret_mstatus: got %h want 00001888", a_csr); else n_pass++;
        csr_raddr = 12'h341; #1;
        n_total++; if (a_csr !== 32'h8000_0040) $display("FAIL mret_mepc_kept: got %h want 80000040", a_csr); else n_pass++;
        pc = 32'hFFFF_FFFC; #1;
        n_total++; if (a_npc !== 32'd0) $display("FAIL npc_wrap: got %h want 0", a_npc); else n_pass++;
        wb_valid = 1'b1; csr_op = 2'd3; pc = 32'h0000_0100; csr_we = 1'b1; csr_waddr = 12'h342; csr_wdata = 32'h55; #1;
        n_total++; if (a_npc !== 32'h0000_0104) $display("FAIL op3_npc: got %h want 00000104", a_npc); else n_pass++;
        tick(); csr_waddr = 12'h340; csr_wdata = 32'h77; tick();
        idle_inputs(); csr_raddr = 12'h342; #2;
        n_total++; if (a_csr !== 32'h55) $display("FAIL op3_csr_write: got %h want 00000055", a_csr); else n_pass++;
        csr_raddr = 12'h340; #1;
        n_total++; if (a_csr !== 32'd0) $display("FAIL unmapped_csr: got %h want 0", a_csr); else n_pass++;
    endtask

    task automatic test_nr16();
        idle_inputs(); wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd20; wb_data = 32'h2020_2020; rs1_addr = 5'd20;
        tick(); idle_inputs(); #2;
        n_total++; if (b_rs1 !== 32'd0) $display("FAIL nr16_x20: got %h want 0", b_rs1); else n_pass++;
        n_total++; if (a_rs1 !== 32'h2020_2020) $display("FAIL nr32_x20: got %h want 20202020", a_rs1); else n_pass++;
        wb_valid = 1'b1; wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h3333_3333; rs2_addr = 5'd3; #2;
        n_total++; if (b_rs2 !== exp_gpr(5'd3, 16)) $display("FAIL nr16_x3_same: got %h want %h", b_rs2, exp_gpr(5'd3, 16)); else n_pass++;
        tick(); idle_inputs(); #2;
        n_total++; if (b_rs2 !== 32'h3333_3333) $display("FAIL nr16_x3: got %h want 33333333", b_rs2); else n_pass++;
    endtask

    task automatic test_random();
        logic [11:0] csr_set [5];
        int n;
        csr_set[0] = 12'h300; csr_set[1] = 12'h305; csr_set[2] = 12'h341; csr_set[3] = 12'h342; csr_set[4] = 12'h7C0;
        for (int it = 0; it < 300; it++) begin
            idle_inputs();
            wb_valid   = ($urandom_range(0, 3) != 0);
            wb_is_load = ($urandom_range(0, 2) == 0);
            wb_we      = $urandom_range(0, 1) == 1;
            wb_rd      = 5'($urandom_range(0, 31));
            wb_data    = $urandom;
            csr_op     = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            csr_we     = $urandom_range(0, 1) == 1;
            csr_waddr  = csr_set[$urandom_range(0, 4)];
            csr_wdata  = $urandom;
            pc         = $urandom;
            n = (wb_valid && wb_is_load) ? $urandom_range(0, 3) : 0;
            for (int c = 0; c <= n; c++) begin
                mem_ready = (c == n) ? 1'b1 : 1'b0;
                if (!wb_is_load) mem_ready = $urandom_range(0, 1) == 1;
                rs1_addr = 5'($urandom_range(0, 31));
                rs2_addr = ($urandom_range(0, 1) == 1) ? wb_rd : 5'($urandom_range(0, 31));
                csr_raddr = csr_set[$urandom_range(0, 4)];
                #2;
                n_total++; if (a_ready !== (c == n)) $display("FAIL rnd_ready[%0d]: got %b want %b", it, a_ready, c == n); else n_pass++;
                n_total++; if (a_npc !== exp_npc()) $display("FAIL rnd_npc[%0d]: got %h want %h", it, a_npc, exp_npc()); else n_pass++;
                n_total++; if (a_rs1 !== exp_gpr(rs1_addr, 32)) $display("FAIL rnd_rs1[%0d]: got %h want %h", it, a_rs1, exp_gpr(rs1_addr, 32)); else n_pass++;
                n_total++; if (a_rs2 !== exp_gpr(rs2_addr, 32)) $display("FAIL rnd_rs2[%0d]: got %h want %h", it, a_rs2, exp_gpr(rs2_addr, 32)); else n_pass++;
                n_total++; if (b_rs1 !== exp_gpr(rs1_addr, 16)) $display("FAIL rnd_rs1_16[%0d]: got %h want %h", it, b_rs1, exp_gpr(rs1_addr, 16)); else n_pass++;
                n_total++; if (b_rs2 !== exp_gpr(rs2_addr, 16)) $display("FAIL rnd_rs2_16[%0d]: got %h want %h", it, b_rs2, exp_gpr(rs2_addr, 16)); else n_pass++;
                n_total++; if (a_csr !== exp_csr(csr_raddr)) $display("FAIL rnd_csr[%0d]: got %h want %h", it, a_csr, exp_csr(csr_raddr)); else n_pass++;
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_load_wait();
        test_ecall_mret();
        test_nr16();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
